muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative RV32M multiply/divide sequencer for the execute stage. It sits beside the single-cycle ALU and takes any M-extension operation the ALU cannot finish in one cycle. It accepts one operation through a valid/ready handshake, runs a 32-step shift-add or restoring-divide loop, applies sign correction, and holds the result until writeback takes it. The execute stage stalls on `busy`.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_valid`  in  1  operation request.
- `start_ready`  out  1  high only in IDLE.
- `op`  in  3  RV32M funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `src_a`  in  32  rs1 (multiplicand/dividend).
- `src_b`  in  32  rs2 (multiplier/divisor).
- `flush`  in  1  abort any in-flight operation.
- `result`  out  32  final value; valid while `result_valid`.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  writeback accepts the result.
- `busy`  out  1  state != IDLE.

## Operation
- **States:** IDLE, PREP, CALC, FIX, DONE.
- **IDLE:**
  - Acceptance = `start_valid && start_ready && !flush`.
  - On acceptance, capture `op`, `src_a` and `src_b`, then go to PREP. Inputs may change after capture.
- **PREP:** record the operand signs and replace signed operands with their absolute values.
  - Signed operands: MULH both; MULHSU `src_a` only; DIV/REM both.
  - Fast paths go straight to DONE:
    - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `src_a`.
    - DIV/REM with 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000, REM → 0.
  - All other operations load the 6-bit iteration counter with 32 and go to CALC.
- **CALC:** exactly 32 cycles, then FIX.
  - Multiply: 64-bit {hi,lo} accumulator. Per step: if `lo[0]`, hi += multiplicand using a 33-bit sum; then shift the 65-bit {carry,hi,lo} right by 1.
  - Divide: restoring. Shift {rem,quot} left by 1, trial-subtract the divisor with a 33-bit difference, set `quot[0]` when the difference is non-negative, and keep the difference in that case.
- **FIX:** negate, then select, then go to DONE.
  - Product: negated (64-bit two's complement) when the operand signs differ.
  - Quotient: negated when the signs differ.
  - Remainder: takes the dividend's sign.
  - Selection: MUL → product low word; MULH/MULHSU/MULHU → product high word.
- **DONE:**
  - `result_valid`=1 and `result` stable until `result_ready`.
  - On the handshake, go to IDLE; `start_ready` rises the following cycle. There is no same-cycle re-accept.
- **`flush`:** from any state, next state is IDLE and `result_valid` drops next cycle. `flush` dominates a simultaneous `start_valid` or `result_ready`.

## Timing
- **Reset (asynchronous):**
  - State IDLE.
  - `result`=0, `result_valid`=0, `busy`=0, `start_ready`=1 after reset.
  - Reset mid-operation discards all state.
- **Latency, normal path:** with acceptance at edge E0, the state is DONE (`result_valid`=1) after E0+35 edges: 1 PREP + 32 CALC + 1 FIX + 1.
- **Latency, fast path:** `result_valid`=1 after E0+2 edges.
- **Registered outputs:** `result` and `result_valid`.
- **Combinational outputs:** `start_ready` and `busy`, decoded from the state register only.
- **Throughput:** one operation per 36 cycles, assuming `result_ready` is held high.

## Structure
- Shared package `muldiv_pkg` holds:
  - `muldiv_op_e`: the 3-bit funct3 encodings.
  - `muldiv_state_e`: IDLE/PREP/CALC/FIX/DONE.
  - Constants `MULDIV_ITER`=32, `DIV0_QUOT`=32'hFFFFFFFF, `INT_MIN`=32'h80000000.
- Single module, no sub-module. The 33-bit add/sub step is inline: the ALU has no carry-out and stays untouched.

## Test plan
1. MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB. `result_valid` rises exactly 35 edges after acceptance; `busy` is high throughout.
2. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU 100/7 → 14; REMU → 2.
4. Fast paths, each with `result_valid` 2 edges after acceptance:
   - DIVU 5/0 → 0xFFFFFFFF.
   - REM 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
5. Abort paths:
   - `flush` pulsed in the 10th CALC cycle → IDLE next edge, `start_ready`=1, no `result_valid`.
   - `rst_n` low mid-CALC → immediate IDLE, outputs at their reset values.
   - `flush` coincident with `start_valid` → not accepted.
6. Backpressure: hold `result_ready` low 5 cycles in DONE. `result` stays stable and a new `start_valid` is ignored. The handshake then gives `start_ready`=1 on the next cycle, and a back-to-back DIVU 9/3 → 3.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
// Operation encodings follow RV32M funct3.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } muldiv_state_e;

  localparam int          MULDIV_ITER = 32;
  localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring divide on
// operand magnitudes, with sign correction applied once the loop finishes.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  input  logic            result_ready,
  output logic            busy
);

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d;
  // hi/lo hold the product accumulator or {remainder, quotient}; opnd is multiplicand or divisor
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            result_valid_q, result_valid_d;

  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            fast_path;
  logic [XLEN-1:0] fast_result;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_rem_sh;
  logic [XLEN:0]   div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;

  assign accept = start_valid && (state_q == S_IDLE) && !flush;

  // In PREP, lo_q holds the raw src_a and opnd_q the raw src_b.
  assign a_neg = op_a_signed(op_q) && lo_q[XLEN-1];
  assign b_neg = op_b_signed(op_q) && opnd_q[XLEN-1];
  assign abs_a = a_neg ? -lo_q : lo_q;
  assign abs_b = b_neg ? -opnd_q : opnd_q;

  assign fast_path = op_is_div(op_q) &&
                     ((opnd_q == '0) ||
                      (((op_q == OP_DIV) || (op_q == OP_REM)) &&
                       (lo_q == INT_MIN) && (opnd_q == '1)));

  always_comb begin
    fast_result = '0;
    if (opnd_q == '0) begin
      fast_result = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? DIV0_QUOT : lo_q;
    end else if (op_q == OP_DIV) begin
      fast_result = INT_MIN;
    end
  end

  assign mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_rem_sh = {hi_q, lo_q[XLEN-1]};
  assign div_diff   = div_rem_sh - {1'b0, opnd_q};

  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quot_fix = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_rem_q ? -hi_q : hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= OP_MUL;
      hi_q           <= '0;
      lo_q           <= '0;
      opnd_q         <= '0;
      cnt_q          <= '0;
      neg_q          <= 1'b0;
      neg_rem_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      opnd_q         <= opnd_d;
      cnt_q          <= cnt_d;
      neg_q          <= neg_d;
      neg_rem_q      <= neg_rem_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_PREP;
      S_PREP: state_d = fast_path ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == 6'd1) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    op_d           = op_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    opnd_d         = opnd_q;
    cnt_d          = cnt_q;
    neg_d          = neg_q;
    neg_rem_d      = neg_rem_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = muldiv_op_e'(op);
          lo_d   = src_a;
          opnd_d = src_b;
        end
      end
      S_PREP: begin
        neg_d     = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        hi_d      = '0;
        cnt_d     = 6'(MULDIV_ITER);
        if (op_is_div(op_q)) begin
          lo_d   = abs_a;
          opnd_d = abs_b;
        end else begin
          lo_d   = abs_b;
          opnd_d = abs_a;
        end
        if (fast_path) begin
          result_d       = fast_result;
          result_valid_d = 1'b1;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - 6'd1;
        if (op_is_div(op_q)) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_rem_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
      end
      S_FIX: begin
        unique case (op_q)
          OP_MUL:                       result_d = prod_fix[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:              result_d = quot_fix;
          default:                      result_d = rem_fix;
        endcase
        result_valid_d = 1'b1;
      end
      S_DONE: if (result_ready) result_valid_d = 1'b0;
      default: ;
    endcase
    if (flush) result_valid_d = 1'b0;
  end

  always_comb begin
    start_ready = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases, abort paths and
// randomized operations compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'(signed'(a));
    longint      sb = longint'(signed'(b));
    longint      ua = longint'({32'h0, a});
    longint      ub = longint'({32'h0, b});
    logic [63:0] p;
    int          ia = signed'(a);
    int          ib = signed'(b);
    int          q;
    case (o)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = ia / ib;
        return 32'(q);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = ia % ib;
        return 32'(q);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges counted from the accepting edge (1) to the edge after which result_valid is high.
  function automatic int model_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0)) return 2;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
    int          lat;
    logic        busy_ok;
    logic [31:0] exp_res;
    logic [31:0] held;
    exp_res = model(o, a, b);
    check("start_ready_before", 32'(start_ready), 32'd1);
    start_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start_valid = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1;
    busy_ok = busy;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      busy_ok = busy_ok & busy;
    end
    check("latency", 32'(lat), 32'(model_latency(o, a, b)));
    check("busy_hold", 32'(busy_ok), 32'd1);
    check("result", result, exp_res);
    if (!result_valid) begin
      flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    end
    held = result;
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1; op = 3'd5; src_a = 32'd77; src_b = 32'd7;
      @(posedge clk); #1;
      check("bp_result_stable", result, held);
      check("bp_valid", 32'(result_valid), 32'd1);
      check("bp_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("valid_drop", 32'(result_valid), 32'd0);
    check("ready_after_hs", 32'(start_ready), 32'd1);
    $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", o, a, b, held, exp_res, lat);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_result", result, 32'h0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Divide cases
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);

    // Fast paths
    run_op(3'd5, 32'd5, 32'd0, 0);
    run_op(3'd6, 32'd5, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush in the 10th CALC cycle
    start_valid = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_start_ready", 32'(start_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    begin
      logic seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen = seen | result_valid; end
      check("flush_no_valid", 32'(seen), 32'd0);
    end
    $display("flush mid-CALC: start_ready=%0d busy=%0d", start_ready, busy);

    // Asynchronous reset mid-CALC
    start_valid = 1'b1; op = 3'd4; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", result, 32'h0);
    check("arst_valid", 32'(result_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_start_ready", 32'(start_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-CALC: result=%h busy=%0d", result, busy);

    // Flush coincident with start_valid
    start_valid = 1'b1; flush = 1'b1; op = 3'd5; src_a = 32'd9; src_b = 32'd3;
    @(posedge clk); #1;
    start_valid = 1'b0; flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);
    check("flush_start_ready", 32'(start_ready), 32'd1);
    $display("flush with start: busy=%0d", busy);

    // Backpressure then back-to-back operation
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 5);
    run_op(3'd5, 32'd9, 32'd3, 0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  ro = 3'($urandom_range(0, 7));
      logic [31:0] ra = pick_operand();
      logic [31:0] rb = pick_operand();
      run_op(ro, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
